// File: rtl/countdown_timer.sv
// Minutes:seconds BCD countdown timer. The divider output tick_clk is sampled as data,
// synchronised, edge detected and prescaled into one-second decrement steps.
module countdown_timer #(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       tick_clk,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_edge;

    logic [1:0]    state_q, state_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, done_q;

    // Flops reset high so a tick_clk already high at reset never looks like a rising edge.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_clk};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [7:0] clamp_sec(input logic [7:0] s);
        logic [7:0] c;
        c = {clamp_digit(s[7:4]), clamp_digit(s[3:0])};
        return (c[7:4] > 4'd5) ? 8'h59 : c;
    endfunction

    // BCD decrement of {min, sec}; seconds tens wrap to 5, all other digits to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = v[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        if (load) begin
            state_d = ST_IDLE;
            min_d   = {clamp_digit(load_min[7:4]), clamp_digit(load_min[3:0])};
            sec_d   = clamp_sec(load_sec);
            presc_d = '0;
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start && state_q == ST_IDLE) begin
            if ({min_q, sec_q} == 16'h0000) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        end else if (start && state_q == ST_PAUSED) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && tick_edge) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                // Reaching zero and entering DONE happen on the same edge.
                if ({min_q, sec_q} == 16'h0001) begin
                    state_d = ST_DONE;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else begin
                    {min_d, sec_d} = bcd_dec({min_q, sec_q});
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign min     = min_q;
    assign sec     = sec_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (1 and 4 ticks per second) checked every cycle
// against a total-seconds reference model, plus directed sequences and a clamp table.
module tb_countdown_timer;

    localparam int SYNC = 2;
    localparam int NI   = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic       sysclk = 1'b0;
    logic       rst, tick_clk, load, start, pause;
    logic [7:0] load_min, load_sec;
    logic [7:0] d_min [NI];
    logic [7:0] d_sec [NI];
    logic       d_run [NI];
    logic       d_done[NI];

    countdown_timer #(.SYNC_STAGES(SYNC), .TICKS_PER_SEC(1)) dut (
        .sysclk(sysclk), .rst(rst), .tick_clk(tick_clk), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
        .min(d_min[0]), .sec(d_sec[0]), .running(d_run[0]), .done(d_done[0])
    );

    countdown_timer #(.SYNC_STAGES(SYNC), .TICKS_PER_SEC(4)) dut4 (
        .sysclk(sysclk), .rst(rst), .tick_clk(tick_clk), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
        .min(d_min[1]), .sec(d_sec[1]), .running(d_run[1]), .done(d_done[1])
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time as plain seconds.
    int m_total[NI];
    int m_mode [NI];
    int m_presc[NI];
    int sq[$];
    bit rose;
    int step_cnt = 0;

    int tick_mode = 0;
    int tick_ctr  = 0;
    int tick_left = 5;

    typedef struct {
        logic [7:0] lm;
        logic [7:0] ls;
        logic [7:0] em;
        logic [7:0] es;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_chk(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout actual=expired required=event at %0t", name, $time);
        end
    endtask

    function automatic int clamp_total(input logic [7:0] lm, input logic [7:0] ls);
        int mt, mo, st, so, m, s;
        mt = (lm >> 4) > 9 ? 9 : int'(lm >> 4);
        mo = (lm & 8'h0f) > 9 ? 9 : int'(lm & 8'h0f);
        st = (ls >> 4) > 9 ? 9 : int'(ls >> 4);
        so = (ls & 8'h0f) > 9 ? 9 : int'(ls & 8'h0f);
        m = mt * 10 + mo;
        s = st * 10 + so;
        if (s > 59) s = 59;
        return m * 60 + s;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic model_inst(input int i, input bit se);
        int tps;
        tps = (i == 0) ? 1 : 4;
        if (rst) begin
            m_total[i] = 0; m_mode[i] = M_IDLE; m_presc[i] = 0;
        end else if (load) begin
            m_total[i] = clamp_total(load_min, load_sec); m_mode[i] = M_IDLE; m_presc[i] = 0;
        end else if (pause) begin
            if (m_mode[i] == M_RUN) m_mode[i] = M_PAUSED;
        end else if (start && m_mode[i] == M_IDLE) begin
            if (m_total[i] == 0) m_mode[i] = M_DONE;
            else begin m_mode[i] = M_RUN; m_presc[i] = 0; end
        end else if (start && m_mode[i] == M_PAUSED) begin
            m_mode[i] = M_RUN;
        end else if (m_mode[i] == M_RUN && se) begin
            m_presc[i]++;
            if (m_presc[i] == tps) begin
                m_presc[i] = 0;
                m_total[i]--;
                if (m_total[i] == 0) m_mode[i] = M_DONE;
            end
        end
    endtask

    // sq holds tick_clk samples of the last SYNC+1 edges, oldest first.
    task automatic model_edge();
        bit se;
        se   = (sq[1] == 1) && (sq[0] == 0);
        rose = !rst && tick_clk && (sq[SYNC] == 0);
        if (se) step_cnt++;
        for (int i = 0; i < NI; i++) model_inst(i, se);
        if (rst) begin
            for (int j = 0; j <= SYNC; j++) sq[j] = 1;
        end else begin
            void'(sq.pop_front());
            sq.push_back(int'(tick_clk));
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d_min", i), d_min[i], to_bcd(m_total[i] / 60));
            chk($sformatf("i%0d_sec", i), d_sec[i], to_bcd(m_total[i] % 60));
            chk($sformatf("i%0d_running", i), d_run[i], int'(m_mode[i] == M_RUN));
            chk($sformatf("i%0d_done", i), d_done[i], int'(m_mode[i] == M_DONE));
        end
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_edge();
        #1;
        compare_all();
        if (tick_mode == 1) begin
            tick_ctr = (tick_ctr + 1) % 20;
            tick_clk = (tick_ctr >= 10);
        end else if (tick_mode == 2) begin
            tick_left--;
            if (tick_left == 0) begin
                tick_clk  = ~tick_clk;
                tick_left = $urandom_range(SYNC + 1, 9);
            end
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_min = m; load_sec = s; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic sync_low();
        int n;
        n = 0;
        do begin cycle(); n++; end while (tick_ctr != 0 && n < 25);
        bound_chk("sync_low", tick_ctr == 0);
    endtask

    task automatic wait_rose();
        int n;
        n = 0;
        do begin cycle(); n++; end while (!rose && n < 50);
        bound_chk("wait_rose", rose);
    endtask

    task automatic wait_steps(input int target, input string name);
        int n;
        n = 0;
        while (step_cnt < target && n < 400) begin cycle(); n++; end
        bound_chk(name, step_cnt >= target);
    endtask

    task automatic step_test(input logic [7:0] lm, input logic [7:0] ls,
                             input logic [7:0] em, input logic [7:0] es, input string name);
        sync_low();
        do_load(lm, ls);
        do_start();
        wait_rose();
        cycle();
        chk({name, "_k1_min"}, d_min[0], lm);
        chk({name, "_k1_sec"}, d_sec[0], ls);
        cycle();
        chk({name, "_k2_min"}, d_min[0], em);
        chk({name, "_k2_sec"}, d_sec[0], es);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_dec, base;
        logic [7:0] pm, ps;

        vecs[0] = '{8'hAB, 8'h7A, 8'h99, 8'h59};
        vecs[1] = '{8'h12, 8'h34, 8'h12, 8'h34};
        vecs[2] = '{8'h0F, 8'hF0, 8'h09, 8'h59};
        vecs[3] = '{8'h99, 8'h60, 8'h99, 8'h59};
        vecs[4] = '{8'h00, 8'h65, 8'h00, 8'h59};
        vecs[5] = '{8'h05, 8'h59, 8'h05, 8'h59};
        vecs[6] = '{8'h3A, 8'h09, 8'h39, 8'h09};

        for (int j = 0; j <= SYNC; j++) sq.push_back(1);
        for (int i = 0; i < NI; i++) begin m_total[i] = 0; m_mode[i] = M_IDLE; m_presc[i] = 0; end
        rst = 1'b1; tick_clk = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;

        // Reset with tick_clk held high.
        repeat (3) cycle();
        rst = 1'b0;
        chk("reset_min", d_min[0], 8'h00);
        chk("reset_sec", d_sec[0], 8'h00);
        chk("reset_running", d_run[0], 0);
        chk("reset_done", d_done[0], 0);
        repeat (5) cycle();
        chk("reset_hold_sec", d_sec[0], 8'h00);

        tick_mode = 1; tick_ctr = 10;

        // Borrow chain 01:00 down to done.
        step_test(8'h01, 8'h00, 8'h00, 8'h59, "borrow");
        n_dec = 1; n = 0;
        while (!d_done[0] && n < 1300) begin
            pm = d_min[0]; ps = d_sec[0];
            cycle(); n++;
            if (d_min[0] != pm || d_sec[0] != ps) n_dec++;
        end
        bound_chk("borrow_done", d_done[0]);
        chk("borrow_done_min", d_min[0], 8'h00);
        chk("borrow_done_sec", d_sec[0], 8'h00);
        chk("borrow_done_running", d_run[0], 0);
        chk("borrow_decrements", n_dec, 60);

        step_test(8'h10, 8'h00, 8'h09, 8'h59, "tens_min");
        step_test(8'h00, 8'h10, 8'h00, 8'h09, "tens_sec");

        // Pause/resume with the four-ticks-per-second instance.
        sync_low();
        do_load(8'h05, 8'h00);
        do_start();
        base = step_cnt;
        wait_steps(base + 2, "pr_two");
        pause = 1'b1; cycle(); pause = 1'b0;
        wait_steps(base + 12, "pr_ten");
        chk("pr_paused_min", d_min[1], 8'h05);
        chk("pr_paused_sec", d_sec[1], 8'h00);
        chk("pr_paused_running", d_run[1], 0);
        do_start();
        wait_steps(base + 13, "pr_e1");
        chk("pr_e1_sec", d_sec[1], 8'h00);
        wait_steps(base + 14, "pr_e2");
        chk("pr_e2_min", d_min[1], 8'h04);
        chk("pr_e2_sec", d_sec[1], 8'h59);
        chk("pr_e2_running", d_run[1], 1);

        // Pause coincident with a step edge drops the step.
        sync_low();
        do_load(8'h00, 8'h30);
        do_start();
        wait_rose();
        cycle();
        pause = 1'b1; cycle(); pause = 1'b0;
        chk("pause_coinc_sec", d_sec[0], 8'h30);
        chk("pause_coinc_running", d_run[0], 0);

        // Load clamp table.
        for (int v = 0; v < 7; v++) begin
            do_load(vecs[v].lm, vecs[v].ls);
            chk($sformatf("clamp%0d_min", v), d_min[0], vecs[v].em);
            chk($sformatf("clamp%0d_sec", v), d_sec[0], vecs[v].es);
        end

        // Zero start goes straight to DONE.
        do_load(8'h00, 8'h00);
        do_start();
        chk("zero_start_done", d_done[0], 1);
        chk("zero_start_running", d_run[0], 0);
        do_start();
        chk("done_ignores_start", d_done[0], 1);

        // Load beats start while running.
        step_test(8'h03, 8'h00, 8'h02, 8'h59, "prio_run");
        load_min = 8'h02; load_sec = 8'h30; load = 1'b1; start = 1'b1;
        cycle();
        load = 1'b0; start = 1'b0;
        chk("prio_min", d_min[0], 8'h02);
        chk("prio_sec", d_sec[0], 8'h30);
        chk("prio_running", d_run[0], 0);
        repeat (30) cycle();
        chk("prio_idle_sec", d_sec[0], 8'h30);

        // Reset mid-countdown at 00:45.
        sync_low();
        do_load(8'h00, 8'h50);
        do_start();
        n = 0;
        while (!(d_min[0] == 8'h00 && d_sec[0] == 8'h45) && n < 200) begin cycle(); n++; end
        bound_chk("reach_0045", d_sec[0] == 8'h45);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("midrst_sec", d_sec[0], 8'h00);
        chk("midrst_running", d_run[0], 0);
        chk("midrst_done", d_done[0], 0);
        repeat (40) cycle();
        chk("midrst_hold_sec", d_sec[0], 8'h00);

        // Randomized stimulus against the model.
        tick_mode = 2; tick_left = 5;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            load     = ($urandom_range(0, 99) < 3);
            load_min = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            load_sec = 8'($urandom);
            start    = ($urandom_range(0, 99) < 8);
            pause    = ($urandom_range(0, 99) < 4);
            cycle();
        end
        rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
